// File: rtl/axi_defines.sv
// Shared AXI-Lite definitions used by masters and responders.
package axi_defines;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

endpackage

// File: rtl/axil_mem_slave_if.sv
// AXI-Lite bus bundle: 32-bit address/data, 4-bit strobes.
interface axil_interface;
    import axi_defines::*;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    axil_resp_t  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    axil_resp_t  rresp;
    logic        rvalid;
    logic        rready;

    modport axil_master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport axil_slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axil_mem_slave_spram_be.sv
// Single-port word RAM with per-byte write enables.
// Registered read port, one cycle of latency.
module spram_be #(
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/axil_mem_slave.sv
// AXI-Lite memory responder; read and write channels share one
// RAM port through a round-robin arbiter.
module axil_mem_slave
    import axi_defines::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter string       INIT_FILE  = ""
) (
    input  logic           clk,
    input  logic           rst_n,
    axil_interface.axil_slave axil_bus,
    output logic           access_err
);

    typedef enum logic [1:0] {
        IDLE, RD_MEM, RD_RESP, WR_RESP
    } state_t;

    localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

    state_t state_q, state_d;
    logic   last_wr_q;
    logic   rd_req, wr_req, rd_gnt, wr_gnt;

    axil_resp_t ar_resp, aw_resp, ar_resp_q;
    axil_resp_t rresp_q, bresp_q;
    logic [31:0] rdata_q;
    logic        rvalid_q, bvalid_q, err_q;

    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_dout;
    logic                  unused_prot;

    // Addresses below the window wrap to a huge offset.
    function automatic axil_resp_t decode(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if ({1'b0, off} >= SPAN) return DECERR;
        if (addr[1:0] != 2'b00) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_idx(
        input logic [31:0] addr
    );
        return ADDR_WIDTH'((addr - BASE_ADDR) >> 2);
    endfunction

    assign unused_prot = ^{axil_bus.arprot, axil_bus.awprot};

    assign rd_req  = axil_bus.arvalid;
    assign wr_req  = axil_bus.awvalid & axil_bus.wvalid;
    assign ar_resp = decode(axil_bus.araddr);
    assign aw_resp = decode(axil_bus.awaddr);

    always_comb begin
        state_d = state_q;
        rd_gnt  = 1'b0;
        wr_gnt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                rd_gnt = rd_req & (~wr_req | last_wr_q);
                wr_gnt = wr_req & (~rd_req | ~last_wr_q);
                if (rd_gnt)      state_d = RD_MEM;
                else if (wr_gnt) state_d = WR_RESP;
            end
            RD_MEM:  state_d = RD_RESP;
            RD_RESP: if (axil_bus.rready) state_d = IDLE;
            WR_RESP: if (axil_bus.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign axil_bus.arready = rd_gnt;
    assign axil_bus.awready = wr_gnt;
    assign axil_bus.wready  = wr_gnt;

    assign ram_en   = rd_gnt | wr_gnt;
    assign ram_we   = (wr_gnt && aw_resp == OKAY) ? axil_bus.wstrb : 4'b0000;
    assign ram_addr = rd_gnt ? word_idx(axil_bus.araddr)
                             : word_idx(axil_bus.awaddr);

    spram_be #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (axil_bus.wdata),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b1;
            ar_resp_q <= OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (rd_gnt) begin
                ar_resp_q <= ar_resp;
                last_wr_q <= 1'b0;
            end
            if (wr_gnt) begin
                bvalid_q  <= 1'b1;
                bresp_q   <= aw_resp;
                last_wr_q <= 1'b1;
                err_q     <= (aw_resp != OKAY);
            end
            // RAM output is valid in RD_MEM; capture it once.
            if (state_q == RD_MEM) begin
                rvalid_q <= 1'b1;
                rresp_q  <= ar_resp_q;
                rdata_q  <= (ar_resp_q == OKAY) ? ram_dout : '0;
                err_q    <= (ar_resp_q != OKAY);
            end
            if (state_q == RD_RESP && axil_bus.rready) rvalid_q <= 1'b0;
            if (state_q == WR_RESP && axil_bus.bready) bvalid_q <= 1'b0;
        end
    end

    assign axil_bus.rvalid = rvalid_q;
    assign axil_bus.rdata  = rdata_q;
    assign axil_bus.rresp  = rresp_q;
    assign axil_bus.bvalid = bvalid_q;
    assign axil_bus.bresp  = bresp_q;
    assign access_err      = err_q;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Scoreboard bench for axil_mem_slave: randomized traffic checked
// against an associative-array memory model.
module tb_axil_mem_slave;
    import axi_defines::*;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic access_err;

    always #5 clk = ~clk;

    axil_interface bus ();

    axil_mem_slave #(
        .ADDR_WIDTH (12),
        .BASE_ADDR  (BASE),
        .INIT_FILE  ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axil_bus   (bus),
        .access_err (access_err)
    );

    typedef struct {
        logic [31:0] data;
        axil_resp_t  resp;
    } rexp_t;

    int total = 0;
    int bad = 0;
    rexp_t rq[$];
    axil_resp_t wq[$];
    logic [31:0] mdl [int];
    int glog[$];
    int cyc = 0, ar_cyc = 0, aw_cyc = 0;
    logic rv_prev = 0, bv_prev = 0, rhold = 0;
    logic [31:0] rdata_prev;
    axil_resp_t rresp_prev;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want handshake", name);
    endfunction

    // Model decode: 16 KiB window at BASE, word aligned.
    function automatic axil_resp_t mresp(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 32'h4000) return DECERR;
        if (a % 4 != 0) return SLVERR;
        return OKAY;
    endfunction

    function automatic int midx(logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev = 0;
            bv_prev = 0;
            rhold = 0;
        end else begin
            cyc++;
            check("excl_ready", 32'(bus.arready & bus.awready), 0);
            if (bus.rvalid || bus.bvalid)
                check("ready_busy",
                      {29'd0, bus.arready, bus.awready, bus.wready}, 0);
            if (bus.arvalid && bus.arready) begin
                ar_cyc = cyc;
                glog.push_back(0);
            end
            if (bus.awvalid && bus.awready) begin
                aw_cyc = cyc;
                glog.push_back(1);
            end
            if (bus.rvalid && !rv_prev) begin
                check("r_latency", 32'(cyc - ar_cyc), 2);
                if (rq.size() > 0)
                    check("r_err", 32'(access_err), 32'(rq[0].resp != OKAY));
            end else if (bus.bvalid && !bv_prev) begin
                check("b_latency", 32'(cyc - aw_cyc), 1);
                if (wq.size() > 0)
                    check("b_err", 32'(access_err), 32'(wq[0] != OKAY));
            end else begin
                check("err_idle", 32'(access_err), 0);
            end
            if (rhold && bus.rvalid) begin
                check("rdata_stable", bus.rdata, rdata_prev);
                check("rresp_stable", 32'(bus.rresp), 32'(rresp_prev));
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    timeout("r_unexpected");
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    check("rdata", bus.rdata, e.data);
                    check("rresp", 32'(bus.rresp), 32'(e.resp));
                end
            end
            if (bus.bvalid && bus.bready) begin
                if (wq.size() == 0) begin
                    timeout("b_unexpected");
                end else begin
                    axil_resp_t e;
                    e = wq.pop_front();
                    check("bresp", 32'(bus.bresp), 32'(e));
                end
            end
            rhold = bus.rvalid && !bus.rready;
            rdata_prev = bus.rdata;
            rresp_prev = bus.rresp;
            rv_prev = bus.rvalid;
            bv_prev = bus.bvalid;
        end
    end

    task automatic wait_grant(input bit is_w);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (is_w ? bus.awready : bus.arready) break;
            if (++t > 100) begin
                timeout(is_w ? "aw_grant" : "ar_grant");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly);
        axil_resp_t r;
        logic [31:0] w;
        int k, t;
        r = mresp(a);
        wq.push_back(r);
        if (r == OKAY) begin
            w = mdl.exists(midx(a)) ? mdl[midx(a)] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            mdl[midx(a)] = w;
        end
        @(posedge clk);
        #1;
        bus.awaddr = a;
        bus.awprot = 3'($urandom);
        bus.wdata = d;
        bus.wstrb = s;
        bus.awvalid = 1;
        bus.wvalid = 1;
        bus.bready = (dly == 0);
        wait_grant(1);
        bus.awvalid = 0;
        bus.wvalid = 0;
        k = 0;
        t = 0;
        forever begin
            if (bus.bvalid && k >= dly) begin
                bus.bready = 1;
                @(posedge clk);
                #1;
                bus.bready = 0;
                break;
            end
            if (bus.bvalid) k++;
            @(posedge clk);
            #1;
            if (++t > 100) begin
                timeout("b_wait");
                break;
            end
        end
    endtask

    task automatic rd(input logic [31:0] a, input int dly,
                      input bit rst_mid);
        rexp_t e;
        int k, t;
        e.resp = mresp(a);
        e.data = (e.resp == OKAY) ? mdl[midx(a)] : 32'h0;
        rq.push_back(e);
        @(posedge clk);
        #1;
        bus.araddr = a;
        bus.arprot = 3'($urandom);
        bus.arvalid = 1;
        bus.rready = (dly == 0);
        wait_grant(0);
        bus.arvalid = 0;
        if (rst_mid) begin
            rst_n = 0;
            rq.delete();
            bus.rready = 0;
            #3;
            check("rst_rvalid", 32'(bus.rvalid), 0);
            repeat (2) @(negedge clk);
            rst_n = 1;
            @(negedge clk);
            check("post_rst_rvalid", 32'(bus.rvalid), 0);
            check("post_rst_arready", 32'(bus.arready), 0);
            return;
        end
        k = 0;
        t = 0;
        forever begin
            if (bus.rvalid && k >= dly) begin
                bus.rready = 1;
                @(posedge clk);
                #1;
                bus.rready = 0;
                break;
            end
            if (bus.rvalid) k++;
            @(posedge clk);
            #1;
            if (++t > 100) begin
                timeout("r_wait");
                break;
            end
        end
    endtask

    initial begin
        int g, t, op;
        logic [31:0] a;
        bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = 0; bus.arprot = 0;
        bus.arvalid = 0; bus.rready = 0;

        #2;
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_rresp", 32'(bus.rresp), 32'(OKAY));
        check("rst_bresp", 32'(bus.bresp), 32'(OKAY));
        check("rst_rdata", bus.rdata, 0);
        check("rst_err", 32'(access_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Contested requests held from reset: R, W, R, W.
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rq.push_back('{32'h0, DECERR});
            wq.push_back(OKAY);
        end
        mdl[midx(BASE + 32'h100)] = 32'hCAFE_F00D;
        bus.araddr = 32'h0000_FFFC;
        bus.awaddr = BASE + 32'h100;
        bus.wdata = 32'hCAFE_F00D;
        bus.wstrb = 4'hF;
        bus.arvalid = 1;
        bus.awvalid = 1;
        bus.wvalid = 1;
        bus.rready = 1;
        bus.bready = 1;
        g = 0;
        t = 0;
        while (g < 4 && t < 100) begin
            @(negedge clk);
            if (bus.arready) g++;
            if (bus.awready) g++;
            t++;
        end
        if (g < 4) timeout("arb_grants");
        @(posedge clk);
        #1;
        bus.arvalid = 0;
        bus.awvalid = 0;
        bus.wvalid = 0;
        repeat (4) @(posedge clk);
        #1;
        bus.rready = 0;
        bus.bready = 0;
        check("grant_count", 32'(glog.size()), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check("grant_order", 32'(glog[i]), 32'(i % 2));

        // Directed cases.
        wr(BASE + 32'h40, 32'hDEAD_BEEF, 4'hF, 0);
        rd(BASE + 32'h40, 0, 0);
        wr(BASE, 32'h1122_3344, 4'hF, 1);
        wr(BASE, 32'hAABB_CCDD, 4'b0101, 0);
        rd(BASE, 2, 0);
        check("merge_model", mdl[0], 32'h11BB_33DD);
        rd(32'h0000_FFFC, 0, 0);
        rd(32'h0001_4000, 1, 0);
        wr(32'h0001_4000, 32'h0BAD_0BAD, 4'hF, 0);
        rd(BASE, 0, 0);
        wr(BASE + 32'h4, 32'h5555_AAAA, 4'hF, 0);
        rd(BASE + 32'h2, 0, 0);
        wr(BASE + 32'h6, 32'h0BAD_0BAD, 4'hF, 0);
        rd(BASE + 32'h4, 0, 0);
        wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'h0, 0);
        rd(BASE + 32'h4, 0, 0);
        rd(BASE + 32'h40, 5, 0);

        // Random traffic over 16 pre-initialised words.
        for (int i = 0; i < 16; i++)
            wr(BASE + 32'h200 + 32'(4 * i), $urandom, 4'hF,
               int'($urandom_range(0, 2)));
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            a = BASE + 32'h200 + 32'(4 * $urandom_range(0, 15));
            if (op == 7) a = a + 32'($urandom_range(1, 3));
            if (op == 8) a = BASE - 32'(4 * $urandom_range(1, 64));
            if (op == 9) a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 64));
            if ($urandom_range(0, 1) == 1)
                wr(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
            else
                rd(a, int'($urandom_range(0, 3)), 0);
        end

        // Reset during RD_MEM, then a committed write is still there.
        rd(BASE + 32'h40, 0, 1);
        rd(BASE + 32'h40, 0, 0);
        rd(BASE, 0, 0);

        repeat (5) @(posedge clk);
        check("rq_empty", 32'(rq.size()), 0);
        check("wq_empty", 32'(wq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_mem_slave.md
Name: axil_mem_slave

Overview:
- AXI-Lite responder (slave) backed by a single-port, byte-writable word RAM.
- Serves instruction fetch and data accesses issued by AXI-Lite masters such as the fetch unit's memory wrapper.
- Sits on the far side of the core's AXI-Lite bus and maps a window starting at BASE_ADDR (the boot/instruction region).
- Read and write channels share the one RAM port through a round-robin arbiter.

Parameters:
- ADDR_WIDTH, 12, word-address bits; RAM depth is 2^ADDR_WIDTH words of 32 bits (16 KiB default).
- BASE_ADDR, 32'h0001_0000, byte address of word 0. Must be aligned to 4*2^ADDR_WIDTH.
- INIT_FILE, "", hex image loaded at elaboration; empty means contents are undefined.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- axil_bus  interface  axil_interface.axil_slave  AXI-Lite channels AW/W/B/AR/R: 32-bit address, 32-bit data, 4-bit wstrb, 2-bit resp.
- access_err  output  1  one-cycle pulse when an error response is issued.

Behaviour:
- Reset (already decided): reset rst_n, asynchronous, active-low; clock clk.
- Reset values: awready, wready, arready, bvalid and rvalid are 0. bresp and rresp are OKAY. rdata is 0. access_err is 0. State is IDLE. Last-grant flag is WRITE, so the first contested grant goes to read.
- RAM contents are not reset.
- Reset asserted mid-transaction abandons it. A write whose handshake has already completed stays committed.
- States: IDLE, RD_MEM, RD_RESP, WR_RESP.
- IDLE request terms:
  - Read request = arvalid.
  - Write request = awvalid & wvalid. AW and W are accepted only together; a lone awvalid or wvalid is never acknowledged.
- IDLE grant rules:
  - If only one request is present, grant it.
  - If both are present, grant the opposite of the last-grant flag.
  - Ready signals are combinational in IDLE: arready=read grant; awready=wready=write grant. All readys are 0 outside IDLE.
- Read path:
  - AR handshake in cycle N: latch the address and go to RD_MEM.
  - Cycle N+1: RAM read. rdata and rresp are registered and rvalid goes high at N+2 (RD_RESP).
  - rvalid, rdata and rresp hold stable until rready. On the handshake, go to IDLE.
  - Minimum read-to-read spacing is 3 cycles.
- Write path:
  - On the AW+W handshake at the clock edge ending cycle N, the RAM byte lanes with wstrb[i]=1 are written.
  - bvalid is high from N+1 (WR_RESP) and holds until bready; on the handshake, go to IDLE.
  - wstrb=0000 is legal: no update, OKAY response.
- Address decode, with offset = addr - BASE_ADDR in 32-bit unsigned arithmetic:
  - offset >= 4*2^ADDR_WIDTH (this covers addr < BASE_ADDR via wrap-around): DECERR 2'b11. Reads return rdata 0; writes are suppressed.
  - addr[1:0] != 0: SLVERR 2'b10. Reads return 0; writes are suppressed.
  - Otherwise OKAY 2'b00, word index = offset[ADDR_WIDTH+1:2].
- access_err pulses in the cycle rvalid or bvalid first rises with a non-OKAY response.
- Ignored inputs: arprot and awprot.
- Data is stored exactly as written; the master side handles endianness.
- Back-to-back: the IDLE cycle following a response handshake may grant immediately.
- rready or bready held high before valid rises is legal; the handshake then completes on the first valid cycle.

Decomposition:
- axi_defines package: axil_resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), reused by masters.
- The state enum is local to the module.
- Sub-module spram_be: synchronous single-port RAM.
  - Ports: clk, en, we[3:0], addr[ADDR_WIDTH-1:0], din[31:0], dout[31:0].
  - dout is registered, 1-cycle latency; INIT_FILE is passed through.

Test Plan:
- Write 0xDEAD_BEEF to 0x0001_0040 with wstrb=1111, then read 0x0001_0040:
  - bresp=OKAY, bvalid one cycle after the handshake.
  - rdata=0xDEAD_BEEF, rresp=OKAY, rvalid exactly 2 cycles after the AR handshake.
- Write 0x1122_3344 (strb 1111), then 0xAABB_CCDD with strb 0101, to 0x0001_0000; read back -> 0x11BB_33DD.
- Read 0x0000_FFFC and 0x0001_4000 -> rresp=DECERR, rdata=0, access_err pulses once each. A write to 0x0001_4000 -> DECERR, and a subsequent read of 0x0001_0000 is unchanged.
- Read 0x0001_0002 -> SLVERR, rdata=0. A write to 0x0001_0006 -> SLVERR and the word at 0x0001_0004 is unchanged.
- arvalid and awvalid+wvalid raised together from reset, requests held after completion: grants alternate R, W, R, W; arready and awready are never high in the same cycle.
- Hold rready=0 for 5 cycles after rvalid -> rvalid/rdata stable and no other grant. Assert rst_n low during RD_MEM -> rvalid=0 and state IDLE after release.
